// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU, DPC digits per cycle.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips CALC and returns 0 one cycle after accept.
module booth_mul_seq #(
  parameter int DPC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  localparam int NDIG = 17;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic        [1:0]  op_q, op_d;
  logic signed [33:0] m_q, m_d;
  logic        [33:0] q_q, q_d;
  logic signed [67:0] acc_q, acc_d;
  logic        [4:0]  dig_q, dig_d;
  logic               out_valid_q, out_valid_d;
  logic        [31:0] result_q, result_d;
  logic               last_calc;

  function automatic logic signed [33:0] ext_m(input logic [1:0] o, input logic [31:0] a);
    return (o == 2'b11) ? {2'b00, a} : {{2{a[31]}}, a};
  endfunction

  function automatic logic [33:0] ext_q(input logic [1:0] o, input logic [31:0] b);
    return o[1] ? {2'b00, b} : {{2{b[31]}}, b};
  endfunction

  function automatic logic signed [67:0] booth_pp(input logic signed [33:0] m, input logic [2:0] b);
    logic signed [67:0] mx;
    mx = {{34{m[33]}}, m};
    case (b)
      3'b001, 3'b010: return mx;
      3'b011:         return mx <<< 1;
      3'b100:         return -(mx <<< 1);
      3'b101, 3'b110: return -mx;
      default:        return '0;
    endcase
  endfunction

  // Adds the partial products of digits dig..dig+DPC-1, skipping any past the last digit.
  function automatic logic signed [67:0] acc_step(input logic signed [67:0] acc,
                                                  input logic signed [33:0] m,
                                                  input logic [33:0] q,
                                                  input logic [4:0] dig);
    logic signed [67:0] sum;
    logic        [34:0] qx;
    logic        [5:0]  pos;
    int                 idx;
    sum = acc;
    qx  = {q, 1'b0};
    for (int j = 0; j < DPC; j++) begin
      idx = int'(dig) + j;
      if (idx < NDIG) begin
        pos = 6'(2 * idx);
        sum = sum + (booth_pp(m, qx[pos +: 3]) <<< pos);
      end
    end
    return sum;
  endfunction

  assign last_calc = (int'(dig_q) + DPC) >= NDIG;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    m_d         = m_q;
    q_d         = q_q;
    acc_d       = acc_q;
    dig_d       = dig_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d    = op;
          m_d     = ext_m(op, rs1);
          q_d     = ext_q(op, rs2);
          acc_d   = '0;
          dig_d   = '0;
          state_d = CALC;
`ifdef MUL_ZERO_BYPASS_EN
          if (rs1 == 32'd0 || rs2 == 32'd0) state_d = DONE;
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
          dig_d   = '0;
        end else begin
          acc_d = acc_step(acc_q, m_q, q_q, dig_q);
          if (last_calc) begin
            dig_d   = '0;
            state_d = DONE;
          end else begin
            dig_d = dig_q + 5'(DPC);
          end
        end
      end
      DONE: begin
        // A handshake coinciding with flush still counts as delivered.
        if (flush || (out_valid_q && out_ready)) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (!out_valid_q) begin
          out_valid_d = 1'b1;
          result_d    = (op_q == 2'b00) ? acc_q[31:0] : acc_q[63:32];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      m_q         <= '0;
      q_q         <= '0;
      acc_q       <= '0;
      dig_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      m_q         <= m_d;
      q_q         <= q_d;
      acc_q       <= acc_d;
      dig_q       <= dig_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: DPC=1 and DPC=4 instances, hand-computed products and latencies.
module tb_booth_mul_seq;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic        flush4, in_valid4, out_ready4;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] result4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.DPC(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  booth_mul_seq #(.DPC(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    issue(o, a, b);
    wait_valid(lat);
    res = result;
    @(posedge clk); #1;
  endtask

  int          lat, seen;
  logic [31:0] res;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
    op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // MUL 7 x -3 with latency and handshake.
    issue(2'b00, 32'd7, 32'hFFFFFFFD);
    chk("calc_in_ready", 32'(in_ready), 32'd0);
    chk("calc_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    chk("mul_lat", 32'(lat), 32'd18);
    chk("mul_res", result, 32'hFFFFFFEB);
    @(posedge clk); #1;
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);

    run_op(2'b01, 32'h80000000, 32'h80000000, res, lat);
    chk("mulh_min", res, 32'h40000000);
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
    chk("mulhu_max", res, 32'hFFFFFFFE);
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
    chk("mulhsu_m1", res, 32'hFFFFFFFF);

    // Back-pressure in DONE.
    out_ready = 1'b0;
    issue(2'b00, 32'h00012345, 32'h00000100);
    wait_valid(lat);
    chk("bp_res", result, 32'h01234500);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_res", result, 32'h01234500);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
    chk("bp_rel_valid", 32'(out_valid), 32'd0);

    // flush wins over a request in IDLE.
    flush = 1'b1; in_valid = 1'b1; op = 2'b00; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("idle_flush_busy", 32'(busy), 32'd0);
    chk("idle_flush_in_ready", 32'(in_ready), 32'd1);

    // flush on the 5th CALC cycle.
    issue(2'b00, 32'd5, 32'd6);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    run_op(2'b00, 32'd3, 32'd4, res, lat);
    chk("post_flush_res", res, 32'h0000000C);
    chk("post_flush_lat", 32'(lat), 32'd18);

    // Asynchronous reset mid-CALC.
    issue(2'b00, 32'd9, 32'd9);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);

    // DPC=4 instance.
    op = 2'b00; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("dpc4_lat", 32'(lat), 32'd6);
    chk("dpc4_res", result4, 32'h242D2080);
    @(posedge clk); #1;

    // Zero operand.
    run_op(2'b01, 32'd0, 32'hDEADBEEF, res, lat);
    chk("zero_res", res, 32'd0);
`ifdef MUL_ZERO_BYPASS_EN
    chk("zero_lat", 32'(lat), 32'd1);
`else
    chk("zero_lat", 32'(lat), 32'd18);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
